// File: rtl/core_pkg.sv
// Shared types for the RV32 core pipeline control: forwarding selects,
// hazard FSM states and the default register index width.
package core_pkg;

  localparam int XREG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LD_BUBBLE = 2'b01,
    ST_MEM_WAIT  = 2'b10
  } haz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding comparator for one EX operand: picks the youngest in-flight
// producer of the register read in ID. x0 is never forwarded.
module fwd_unit #(
  parameter int XREG_W = 5
) (
  input  logic [XREG_W-1:0] i_rs,
  input  logic              i_use,
  input  logic [XREG_W-1:0] i_ex_rd,
  input  logic              i_ex_regwrite,
  input  logic [XREG_W-1:0] i_mem_rd,
  input  logic              i_mem_regwrite,
  output logic [1:0]        o_sel
);
  import core_pkg::*;

  // The EX producer is younger than the MEM one, so it wins on a double match.
  always_comb begin
    o_sel = FWD_RF;
    if (i_use && (i_rs != '0)) begin
      if (i_ex_regwrite && (i_ex_rd == i_rs)) begin
        o_sel = FWD_MEM;
      end else if (i_mem_regwrite && (i_mem_rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, data
// memory wait stalls and registered EX forwarding selects.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
// Handshake: the pipeline samples every stall/flush output at the next rising
// edge; stalls hold a register, flushes zero it, stall wins where both apply.
module hazard_ctrl #(
  parameter int XREG_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XREG_W-1:0] id_rs1,
  input  logic [XREG_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XREG_W-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [XREG_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_req,
  input  logic              dmem_ready,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              ctrl_flush,
  output logic              exmem_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [1:0]        dbg_state
);
  import core_pkg::*;

  haz_state_e  r_state;
  haz_state_e  w_state_nxt;
  logic        w_mem_wait;
  logic        w_load_use;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;

  assign w_mem_wait = mem_req & ~dmem_ready;
  assign w_load_use = ex_memread & ex_regwrite & (ex_rd != '0) &
                      ((id_use_rs1 & (ex_rd == id_rs1)) |
                       (id_use_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // LD_BUBBLE re-evaluates hazards exactly like RUN; only MEM_WAIT freezes.
  always_comb begin
    w_state_nxt = r_state;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    ctrl_flush  = 1'b0;
    exmem_stall = 1'b0;
    case (r_state)
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        if (w_mem_wait) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          ctrl_flush = 1'b1;
        end else if (w_load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          ctrl_flush  = 1'b1;
          w_state_nxt = ST_LD_BUBBLE;
        end
      end
    endcase
  end

  fwd_unit #(.XREG_W(XREG_W)) u_fwd_a (
    .i_rs          (id_rs1),
    .i_use         (id_use_rs1),
    .i_ex_rd       (ex_rd),
    .i_ex_regwrite (ex_regwrite),
    .i_mem_rd      (mem_rd),
    .i_mem_regwrite(mem_regwrite),
    .o_sel         (w_fwd_a)
  );

  fwd_unit #(.XREG_W(XREG_W)) u_fwd_b (
    .i_rs          (id_rs2),
    .i_use         (id_use_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_regwrite (ex_regwrite),
    .i_mem_rd      (mem_rd),
    .i_mem_regwrite(mem_regwrite),
    .o_sel         (w_fwd_b)
  );

  // Selects travel with the instruction: hold on stall, clear on bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (idex_stall) begin
      r_fwd_a <= r_fwd_a;
      r_fwd_b <= r_fwd_b;
    end else if (ctrl_flush) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= w_fwd_a;
      r_fwd_b <= w_fwd_b;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign dbg_state = r_state;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating so a long run never wraps back to a misleading small value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ifid_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. Each cycle it resolves data hazards and control hazards, plus data-memory wait states. It drives the 2-bit select of both EX-stage forwarding `threemux32` instances and the bubble input `ctrlf` of the `controllermux` at ID/EX. It also produces PC and IF/ID stall/flush enables. A small FSM sequences load-use bubbles and memory waits; forwarding selects are registered so they are valid during EX.

## Interface
Parameters:
- `XREG_W`, 5, register index width
- `CNT_W`, 32, perf counter width (`HAZ_PERF_CNT_EN` only)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `id_rs1`, `id_rs2` in `XREG_W`: source registers of instruction in ID
- `id_use_rs1`, `id_use_rs2` in 1: instruction in ID actually reads rs1/rs2
- `ex_rd` in `XREG_W`; `ex_regwrite`, `ex_memread` in 1: destination and controls of instruction in EX
- `mem_rd` in `XREG_W`; `mem_regwrite` in 1: destination and write enable of instruction in MEM
- `mem_req` in 1: MEM stage is issuing a load or store
- `dmem_ready` in 1: data memory completes the access this cycle
- `ex_branch_taken` in 1: branch/jump resolved taken in EX
- `pc_stall` out 1: hold PC
- `ifid_stall` out 1: hold IF/ID
- `ifid_flush` out 1: zero IF/ID
- `idex_stall` out 1: hold ID/EX
- `ctrl_flush` out 1: to `controllermux` `ctrlf`; inserts a bubble into ID/EX
- `exmem_stall` out 1: hold EX/MEM and MEM/WB
- `fwd_a_sel`, `fwd_b_sel` out 2: forwarding mux selects; 00 = regfile, 01 = WB result, 10 = MEM result
- `perf_stall_cnt`, `perf_flush_cnt` out `CNT_W`: perf counters

## Operation
- FSM states: RUN, LD_BUBBLE, MEM_WAIT. Reset state is RUN.
- Hazard terms:
  - Load-use: `ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))`.
  - Mem-wait: `mem_req & !dmem_ready`.
- Priority: mem-wait > branch-taken > load-use.
- Behaviour in RUN:
  - On mem-wait: assert all stalls (`pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall`) and go to MEM_WAIT.
  - Else on `ex_branch_taken`: assert `ifid_flush` and `ctrl_flush`. The load-use check is suppressed this cycle, since the ID instruction is discarded.
  - Else on load-use: assert `pc_stall`, `ifid_stall` and `ctrl_flush`, then go to LD_BUBBLE.
- LD_BUBBLE: lasts one cycle. Hazard terms are re-evaluated exactly as in RUN; the next state follows the same rules as RUN.
- MEM_WAIT: all stalls stay asserted while `!dmem_ready`. In the cycle `dmem_ready` rises, stalls drop in that same cycle and the FSM returns to RUN. Branch and load-use are not acted on while frozen.
- Forwarding, computed in ID and registered into `fwd_*_sel` when ID/EX advances. Selection for rs1 (rs2 identical):
  - `ex_regwrite & ex_rd!=0 & ex_rd==id_rs1` gives 10. This producer will be in MEM when the consumer is in EX.
  - Else `mem_regwrite & mem_rd!=0 & mem_rd==id_rs1` gives 01.
  - Else 00.
- Forwarding register update rules:
  - If `id_use_*` is 0, the select is 00.
  - When `idex_stall` is asserted, the registers hold.
  - When `ctrl_flush` is asserted, the registers load 00.
- x0 is never forwarded and never triggers load-use.

## Timing
- Stall and flush outputs are combinational from FSM state plus current inputs. They are valid in the same cycle and must be sampled by pipeline registers at the next edge.
- `fwd_*_sel` are registered, with one cycle of latency from ID to EX.
- A load-use hazard costs exactly 1 bubble cycle. A taken branch costs 2 squashed instructions: IF/ID is zeroed and the ID/EX bubble is inserted in the same cycle.
- Reset values: FSM = RUN; `fwd_a_sel` = `fwd_b_sel` = 00; counters = 0. With inputs idle, all stall/flush outputs are 0.
- If reset is asserted mid-MEM_WAIT or mid-LD_BUBBLE, the next edge returns the FSM to RUN with no pending stall.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `perf_stall_cnt` increments every cycle `pc_stall` is 1.
  - `perf_flush_cnt` increments every cycle `ifid_flush` is 1.
  - Both saturate at all-ones and clear on reset.
- `HAZ_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are instantiated.

## Structure
- Shared package `core_pkg`:
  - `fwd_sel_e` with values `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10.
  - `haz_state_e`.
  - `XREG_W`.
- One sub-module, `fwd_unit`: comparator logic for a single operand, instantiated twice (rs1 and rs2). The FSM and counters live in `hazard_ctrl`.

## Test plan
- Load-use: EX holds `lw x5` (`ex_memread`=1, `ex_rd`=5), ID holds `add x6,x5,x1` -> `pc_stall`, `ifid_stall` and `ctrl_flush` are 1 for one cycle. The next cycle all are 0. When the add reaches EX, `fwd_a_sel`=01.
- Back-to-back ALU ops: `ex_rd`=3 with `ex_regwrite`=1, ID `rs2`=3 -> no stall. Next cycle `fwd_b_sel`=10.
- Double producer: `ex_rd`=`mem_rd`=7, both writing, ID `rs1`=7 -> `fwd_a_sel`=10 (the EX producer wins). With `rs1`=0 the result is 00 regardless of producers.
- Taken branch coincident with load-use -> only `ifid_flush` and `ctrl_flush` assert; no `pc_stall`; FSM stays in RUN.
- `mem_req`=1 with `dmem_ready` low for 3 cycles -> all four stalls high for 3 cycles, dropping in the cycle `dmem_ready`=1. With `HAZ_PERF_CNT_EN` defined, `perf_stall_cnt` reads 3.
- `rst_n` low during MEM_WAIT -> next cycle the FSM is in RUN, all outputs are 0 and the selects are 00.
